// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants for the ALU control decoder and the
// iterative RV32M multiply/divide sequencer.
//   alu_op_e    : 4-bit ALU operation codes driven to the ALU
//   alu_class_e : instruction class codes from the main control unit
//   m_funct3_e  : RV32M funct3 encodings
//   F7_*        : funct7 patterns recognised by the decoder
//   md_state_e  : multiply/divide sequencer states
//   rs1_signed / rs2_signed : operand signedness per M operation
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_LUI  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_BEQ  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_BNE  = 4'b1010,
    ALU_BLT  = 4'b1011,
    ALU_BGE  = 4'b1100,
    ALU_SLT  = 4'b1101,
    ALU_SLTU = 4'b1110
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_R      = 3'b000,
    CLS_I      = 3'b001,
    CLS_MEM    = 3'b010,
    CLS_LUI    = 3'b100,
    CLS_BRANCH = 3'b101,
    CLS_JALR   = 3'b111
  } alu_class_e;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_funct3_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } md_state_e;

  // MUL is treated as signed x signed; its low half is identical either way.
  function automatic logic rs1_signed(input logic [2:0] f3);
    return !(f3 == M_MULHU || f3 == M_DIVU || f3 == M_REMU);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return f3 == M_MUL || f3 == M_MULH || f3 == M_DIV || f3 == M_REM;
  endfunction

endpackage

// File: rtl/alu_md_control_if.sv
// alu_md_control_if: execute-stage bus between the pipeline (master) and the
// ALU control / multiply-divide sequencer (slave).
//   master drives : valid_i, kill_i, funct7_i, ALU_Op_i, funct3_i, rs1_i, rs2_i
//   slave drives  : ALU_Operation_o, illegal_o, stall_o, md_done_o, md_result_o
interface alu_md_control_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_i;
  logic                  kill_i;
  logic [6:0]            funct7_i;
  logic [2:0]            ALU_Op_i;
  logic [2:0]            funct3_i;
  logic [DATA_WIDTH-1:0] rs1_i;
  logic [DATA_WIDTH-1:0] rs2_i;
  logic [3:0]            ALU_Operation_o;
  logic                  illegal_o;
  logic                  stall_o;
  logic                  md_done_o;
  logic [DATA_WIDTH-1:0] md_result_o;

  modport master (
    output valid_i, kill_i, funct7_i, ALU_Op_i, funct3_i, rs1_i, rs2_i,
    input  ALU_Operation_o, illegal_o, stall_o, md_done_o, md_result_o
  );

  modport slave (
    input  valid_i, kill_i, funct7_i, ALU_Op_i, funct3_i, rs1_i, rs2_i,
    output ALU_Operation_o, illegal_o, stall_o, md_done_o, md_result_o
  );
endinterface

// File: rtl/md_iter_unit.sv
// md_iter_unit: one-bit-per-cycle multiply/divide datapath on unsigned
// magnitudes. {hi, lo} is shared: shift-add product for multiply, or
// remainder (hi) / quotient (lo) for restoring divide.
//   clk          : clock
//   load         : initialise from mag_a/mag_b
//   step         : perform one iteration
//   is_div       : (ALU_MD_DIV_EN only) operation selector sampled on load
//   mag_a, mag_b : multiplicand/multiplier or dividend/divisor magnitudes
//   hi, lo       : current accumulator halves
// Macro ALU_MD_DIV_EN: compiles in the restoring divider.
module md_iter_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic                  step,
`ifdef ALU_MD_DIV_EN
  input  logic                  is_div,
`endif
  input  logic [DATA_WIDTH-1:0] mag_a,
  input  logic [DATA_WIDTH-1:0] mag_b,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  logic [DATA_WIDTH-1:0] m_q, hi_q, lo_q, hi_n, lo_n;
  logic [DATA_WIDTH:0]   mul_sum;

  // Multiply: add multiplicand into the high half when the low bit is set,
  // then shift the whole 2*DATA_WIDTH product right by one.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);

`ifdef ALU_MD_DIV_EN
  logic                div_q;
  logic [DATA_WIDTH:0] shifted, diff;

  // Divide: shift the next dividend bit into the partial remainder and
  // keep the subtraction only when it does not borrow.
  assign shifted = {hi_q, lo_q[DATA_WIDTH-1]};
  assign diff    = shifted - {1'b0, m_q};
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hi_n = mul_sum[DATA_WIDTH:1];
    lo_n = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
`ifdef ALU_MD_DIV_EN
    if (div_q) begin
      hi_n = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
      lo_n = {lo_q[DATA_WIDTH-2:0], !diff[DATA_WIDTH]};
    end
`endif
  end

  // NOTE: datapath registers carry no reset; they are always loaded on
  // accept before anything reads them, which keeps reset fan-out small.
  always_ff @(posedge clk) begin
    if (load) begin
      hi_q <= '0;
`ifdef ALU_MD_DIV_EN
      div_q <= is_div;
      m_q   <= is_div ? mag_b : mag_a;
      lo_q  <= is_div ? mag_a : mag_b;
`else
      m_q   <= mag_a;
      lo_q  <= mag_b;
`endif
    end else if (step) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: rtl/alu_md_control.sv
// alu_md_control: execute-stage ALU control decoder plus RV32M sequencer.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : alu_md_control_if.slave
//     ALU_Operation_o / illegal_o : combinational decode of {funct7, ALU_Op, funct3}
//     stall_o   : holds the pipeline while an M operation is accepted/running
//     md_done_o : one-cycle pulse, md_result_o valid
// Macro ALU_MD_DIV_EN: enables DIV/DIVU/REM/REMU; otherwise they decode as illegal.
module alu_md_control
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  alu_md_control_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  alu_op_e   alu_code;
  logic      matched, is_m;
  md_state_e state, state_d;
  logic [CNT_W-1:0] cnt;
  logic      accept, step, fast;
  logic      neg_a, neg_b, neg_a_q, neg_b_q;
  m_funct3_e op_q;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b, acc_hi, acc_lo;
  logic [DATA_WIDTH-1:0]   fast_result, fix_result, mul_res, md_result;
  logic [2*DATA_WIDTH-1:0] prod, prod_fix;

  // ---------------- decode ----------------
  always_comb begin
    alu_code = ALU_ADD;
    matched  = 1'b0;
    is_m     = 1'b0;
    case (bus.ALU_Op_i)
      CLS_R: begin
        case (bus.funct7_i)
          F7_BASE: begin
            matched = 1'b1;
            case (bus.funct3_i)
              3'b000:  alu_code = ALU_ADD;
              3'b001:  alu_code = ALU_SLL;
              3'b010:  alu_code = ALU_SLT;
              3'b011:  alu_code = ALU_SLTU;
              3'b100:  alu_code = ALU_XOR;
              3'b101:  alu_code = ALU_SRL;
              3'b110:  alu_code = ALU_OR;
              default: alu_code = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (bus.funct3_i == 3'b000) begin
              matched  = 1'b1;
              alu_code = ALU_SUB;
            end else if (bus.funct3_i == 3'b101) begin
              matched  = 1'b1;
              alu_code = ALU_SRA;
            end
          end
          F7_MULDIV: begin
`ifdef ALU_MD_DIV_EN
            is_m = 1'b1;
`else
            is_m = !bus.funct3_i[2];
`endif
            matched = is_m;
          end
          default: ;
        endcase
      end
      CLS_I: begin
        // funct7 only qualifies the shift-immediate forms.
        matched = 1'b1;
        case (bus.funct3_i)
          3'b000: alu_code = ALU_ADD;
          3'b001: begin
            matched  = (bus.funct7_i == F7_BASE);
            alu_code = matched ? ALU_SLL : ALU_ADD;
          end
          3'b010: alu_code = ALU_SLT;
          3'b011: alu_code = ALU_SLTU;
          3'b100: alu_code = ALU_XOR;
          3'b101: begin
            if (bus.funct7_i == F7_BASE)     alu_code = ALU_SRL;
            else if (bus.funct7_i == F7_ALT) alu_code = ALU_SRA;
            else                             matched  = 1'b0;
          end
          3'b110:  alu_code = ALU_OR;
          default: alu_code = ALU_AND;
        endcase
      end
      CLS_MEM, CLS_JALR: matched = 1'b1;
      CLS_LUI: begin
        matched  = 1'b1;
        alu_code = ALU_LUI;
      end
      CLS_BRANCH: begin
        matched = 1'b1;
        case (bus.funct3_i)
          3'b000:  alu_code = ALU_BEQ;
          3'b001:  alu_code = ALU_BNE;
          3'b100:  alu_code = ALU_BLT;
          3'b101:  alu_code = ALU_BGE;
          default: matched  = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.ALU_Operation_o = alu_code;
  assign bus.illegal_o       = bus.valid_i & !matched;

  // ---------------- operand preparation ----------------
  assign neg_a = rs1_signed(bus.funct3_i) & bus.rs1_i[DATA_WIDTH-1];
  assign neg_b = rs2_signed(bus.funct3_i) & bus.rs2_i[DATA_WIDTH-1];
  assign mag_a = neg_a ? -bus.rs1_i : bus.rs1_i;
  assign mag_b = neg_b ? -bus.rs2_i : bus.rs2_i;

`ifdef ALU_MD_DIV_EN
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic div_zero, div_ovf;
  logic [DATA_WIDTH-1:0] quo, rem;

  // Divide-by-zero and signed overflow have fixed answers; skip iterating.
  assign div_zero    = (bus.rs2_i == '0);
  assign div_ovf     = !bus.funct3_i[0] && bus.rs1_i == MOST_NEG && bus.rs2_i == '1;
  assign fast        = bus.funct3_i[2] & (div_zero | div_ovf);
  assign fast_result = div_zero ? (bus.funct3_i[1] ? bus.rs1_i : '1)
                                : (bus.funct3_i[1] ? '0 : bus.rs1_i);
`else
  assign fast        = 1'b0;
  assign fast_result = '0;
`endif

  // ---------------- sequencer ----------------
  assign accept = !reset && state == S_IDLE && bus.valid_i && is_m && !bus.kill_i;

  always_comb begin
    state_d = state;
    step    = 1'b0;
    case (state)
      S_IDLE: if (accept) state_d = fast ? S_DONE : S_CALC;
      S_CALC: begin
        if (bus.kill_i) state_d = S_IDLE;
        else begin
          step = 1'b1;
          if (cnt == LAST_ITER) state_d = S_FIX;
        end
      end
      S_FIX:   state_d = bus.kill_i ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      md_result <= '0;
    end else begin
      state <= state_d;
      if (accept)    cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
      if (accept && fast)                    md_result <= fast_result;
      else if (state == S_FIX && !bus.kill_i) md_result <= fix_result;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= m_funct3_e'(bus.funct3_i);
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
    end
  end

  md_iter_unit #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk   (clk),
    .load  (accept),
    .step  (step),
`ifdef ALU_MD_DIV_EN
    .is_div(bus.funct3_i[2]),
`endif
    .mag_a (mag_a),
    .mag_b (mag_b),
    .hi    (acc_hi),
    .lo    (acc_lo)
  );

  // ---------------- sign fix / half select ----------------
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
  assign mul_res  = (op_q == M_MUL) ? prod_fix[DATA_WIDTH-1:0]
                                    : prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef ALU_MD_DIV_EN
  // The remainder follows the dividend's sign only.
  assign quo        = (neg_a_q ^ neg_b_q) ? -acc_lo : acc_lo;
  assign rem        = neg_a_q ? -acc_hi : acc_hi;
  assign fix_result = !op_q[2] ? mul_res : (op_q[1] ? rem : quo);
`else
  assign fix_result = mul_res;
`endif

  assign bus.stall_o     = accept || state == S_CALC || state == S_FIX;
  assign bus.md_done_o   = (state == S_DONE);
  assign bus.md_result_o = md_result;
endmodule

// File: tb/tb_alu_md_control.sv
// tb_alu_md_control: self-checking bench for alu_md_control (DATA_WIDTH=32).
// Decode is table-driven; M operations use a table of known vectors, random
// operands against an arithmetic reference model, and hand-written kill and
// reset sequences. Honours ALU_MD_DIV_EN in the same way as the design.
module tb_alu_md_control;
  localparam int DW = 32;
  localparam int LATENCY = DW + 2;
`ifdef ALU_MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_md_control_if #(.DATA_WIDTH(DW)) bus ();
  alu_md_control #(.DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------- reference model: RV32M semantics in plain arithmetic ----------
  function automatic logic [31:0] m_model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ubs;
    logic [63:0] p;
    logic [31:0] r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ubs = {32'b0, b};
    r   = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ubs; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: if (b == 0) r = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = $signed(a) / $signed(b);
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else r = $signed(a) % $signed(b);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int m_cycles(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
    if (DIV_EN && f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return LATENCY;
  endfunction

  // ---------- decode vectors ----------
  typedef struct {
    logic [2:0] cls;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] code;
    logic       ill;
  } dec_vec_t;
  dec_vec_t dvec[$];

  function automatic void add_dec(input logic [2:0] cls, input logic [6:0] f7,
                                  input logic [2:0] f3, input logic [3:0] code, input logic ill);
    dec_vec_t v;
    v.cls = cls; v.f7 = f7; v.f3 = f3; v.code = code; v.ill = ill;
    dvec.push_back(v);
  endfunction

  // ---------- M-op vectors ----------
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, res;
    int          cyc;
  } m_vec_t;
  m_vec_t mvec[$];

  function automatic void add_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input int cyc);
    m_vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.res = res; v.cyc = cyc;
    mvec.push_back(v);
  endfunction

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i  = 1'b1;
    bus.kill_i   = 1'b0;
    bus.funct7_i = 7'b0000001;
    bus.ALU_Op_i = 3'b000;
    bus.funct3_i = f3;
    bus.rs1_i    = a;
    bus.rs2_i    = b;
  endtask

  // valid_i stays high until the done cycle, like a stalled decode stage.
  task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
    int done_cyc = -1;
    bit stall_ok = 1'b1;
    logic [31:0] res = '0;
    @(negedge clk);
    drive_m(f3, a, b);
    #1 check({tag, "_stall_c0"}, 64'(bus.stall_o), 64'(1));
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (bus.md_done_o === 1'b1) begin
        done_cyc = cyc;
        res = bus.md_result_o;
        if (bus.stall_o !== 1'b0) stall_ok = 1'b0;
      end else if (bus.stall_o !== 1'b1) stall_ok = 1'b0;
    end
    bus.valid_i = 1'b0;
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    if (done_cyc >= 0) check({tag, "_result"}, 64'(res), 64'(exp));
    check({tag, "_stall_shape"}, 64'(stall_ok), 64'(1));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.md_done_o), 64'(0));
  endtask

  task automatic expect_no_done(input string tag, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.md_done_o !== 1'b0) seen = 1'b1;
    end
    check({tag, "_no_done"}, 64'(seen), 64'(0));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Decode table: {class, funct7, funct3, code, illegal}
    add_dec(3'b000, 7'h00, 3'b000, 4'b0000, 1'b0);
    add_dec(3'b000, 7'h00, 3'b001, 4'b0111, 1'b0);
    add_dec(3'b000, 7'h00, 3'b010, 4'b1101, 1'b0);
    add_dec(3'b000, 7'h00, 3'b011, 4'b1110, 1'b0);
    add_dec(3'b000, 7'h00, 3'b100, 4'b0100, 1'b0);
    add_dec(3'b000, 7'h00, 3'b101, 4'b0110, 1'b0);
    add_dec(3'b000, 7'h00, 3'b110, 4'b0011, 1'b0);
    add_dec(3'b000, 7'h00, 3'b111, 4'b0010, 1'b0);
    add_dec(3'b000, 7'h20, 3'b000, 4'b0001, 1'b0);
    add_dec(3'b000, 7'h20, 3'b101, 4'b1001, 1'b0);
    add_dec(3'b000, 7'h20, 3'b001, 4'b0000, 1'b1);
    add_dec(3'b000, 7'h02, 3'b000, 4'b0000, 1'b1);
    add_dec(3'b000, 7'h01, 3'b000, 4'b0000, 1'b0);
    add_dec(3'b000, 7'h01, 3'b101, 4'b0000, !DIV_EN);
    add_dec(3'b001, 7'h55, 3'b000, 4'b0000, 1'b0);
    add_dec(3'b001, 7'h7F, 3'b110, 4'b0011, 1'b0);
    add_dec(3'b001, 7'h00, 3'b001, 4'b0111, 1'b0);
    add_dec(3'b001, 7'h20, 3'b001, 4'b0000, 1'b1);
    add_dec(3'b001, 7'h20, 3'b101, 4'b1001, 1'b0);
    add_dec(3'b001, 7'h00, 3'b101, 4'b0110, 1'b0);
    add_dec(3'b001, 7'h01, 3'b101, 4'b0000, 1'b1);
    add_dec(3'b001, 7'h33, 3'b011, 4'b1110, 1'b0);
    add_dec(3'b010, 7'h20, 3'b010, 4'b0000, 1'b0);
    add_dec(3'b100, 7'h00, 3'b110, 4'b0101, 1'b0);
    add_dec(3'b101, 7'h00, 3'b000, 4'b1000, 1'b0);
    add_dec(3'b101, 7'h00, 3'b001, 4'b1010, 1'b0);
    add_dec(3'b101, 7'h00, 3'b100, 4'b1011, 1'b0);
    add_dec(3'b101, 7'h00, 3'b101, 4'b1100, 1'b0);
    add_dec(3'b101, 7'h00, 3'b010, 4'b0000, 1'b1);
    add_dec(3'b111, 7'h00, 3'b000, 4'b0000, 1'b0);
    add_dec(3'b011, 7'h00, 3'b000, 4'b0000, 1'b1);
    add_dec(3'b110, 7'h00, 3'b000, 4'b0000, 1'b1);

    // Known M results: {funct3, rs1, rs2, result, done cycle}
    add_m(3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, LATENCY);
    add_m(3'b001, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, LATENCY);
    add_m(3'b011, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, LATENCY);
    add_m(3'b010, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, LATENCY);
    add_m(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LATENCY);
`ifdef ALU_MD_DIV_EN
    add_m(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LATENCY);
    add_m(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LATENCY);
    add_m(3'b101, 32'd20, 32'd3, 32'd6, LATENCY);
    add_m(3'b111, 32'd20, 32'd3, 32'd2, LATENCY);
    add_m(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    add_m(3'b110, 32'd5, 32'd0, 32'd5, 1);
    add_m(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    add_m(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    add_m(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LATENCY);
    add_m(3'b111, 32'd7, 32'd0, 32'd7, 1);
`endif

    // ---------- reset ----------
    reset = 1'b1;
    bus.valid_i = 1'b0; bus.kill_i = 1'b0; bus.funct7_i = '0; bus.ALU_Op_i = '0;
    bus.funct3_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", 64'(bus.stall_o), 64'(0));
    check("rst_done", 64'(bus.md_done_o), 64'(0));
    check("rst_result", 64'(bus.md_result_o), 64'(0));
    check("rst_illegal", 64'(bus.illegal_o), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // ---------- decode table (kill held so M encodings cannot start) ----------
    foreach (dvec[i]) begin
      bus.valid_i = 1'b1; bus.kill_i = 1'b1;
      bus.ALU_Op_i = dvec[i].cls; bus.funct7_i = dvec[i].f7; bus.funct3_i = dvec[i].f3;
      #1;
      check($sformatf("dec%0d_code", i), 64'(bus.ALU_Operation_o), 64'(dvec[i].code));
      check($sformatf("dec%0d_illegal", i), 64'(bus.illegal_o), 64'(dvec[i].ill));
      check($sformatf("dec%0d_stall", i), 64'(bus.stall_o), 64'(0));
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    bus.ALU_Op_i = 3'b000; bus.funct7_i = 7'h02; bus.funct3_i = 3'b000;
    #1 check("dec_invalid_not_illegal", 64'(bus.illegal_o), 64'(0));
    bus.kill_i = 1'b0;
    expect_no_done("kill_beats_accept", 4);

    // ---------- known M vectors ----------
    foreach (mvec[i])
      run_m($sformatf("mvec%0d", i), mvec[i].f3, mvec[i].a, mvec[i].b, mvec[i].res, mvec[i].cyc);

`ifndef ALU_MD_DIV_EN
    // ---------- divide disabled ----------
    @(negedge clk);
    drive_m(3'b101, 32'd20, 32'd3);
    #1;
    check("nodiv_illegal", 64'(bus.illegal_o), 64'(1));
    check("nodiv_stall", 64'(bus.stall_o), 64'(0));
    @(negedge clk);
    bus.valid_i = 1'b0;
    expect_no_done("nodiv", 40);
`endif

    // ---------- random vs model ----------
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = DIV_EN ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      run_m($sformatf("rnd%0d_f%0d_%h_%h", n, f3, a, b), f3, a, b, m_model(f3, a, b),
            m_cycles(f3, a, b));
    end

    // ---------- kill mid-operation ----------
    run_m("kill_pre", 3'b000, 32'd7, 32'd6, 32'd42, LATENCY);
    @(negedge clk);
    drive_m(3'b000, 32'h0000_1234, 32'h0000_5678);
    for (int cyc = 1; cyc <= 10; cyc++) @(negedge clk);
    bus.kill_i = 1'b1; bus.valid_i = 1'b0;
    @(negedge clk);
    bus.kill_i = 1'b0;
    check("kill_stall", 64'(bus.stall_o), 64'(0));
    check("kill_result_kept", 64'(bus.md_result_o), 64'(42));
    expect_no_done("kill", 40);

    // ---------- reset mid-operation ----------
    @(negedge clk);
    drive_m(3'b001, 32'hDEAD_BEEF, 32'h1234_5678);
    for (int cyc = 1; cyc <= 10; cyc++) @(negedge clk);
    reset = 1'b1; bus.valid_i = 1'b0;
    #1;
    check("midrst_stall", 64'(bus.stall_o), 64'(0));
    check("midrst_done", 64'(bus.md_done_o), 64'(0));
    check("midrst_result", 64'(bus.md_result_o), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    expect_no_done("midrst", 40);
    run_m("post_rst", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LATENCY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
